// File: rtl/wave_pkg.sv
// Shared definitions for the waveform capture path: default geometry,
// capture FSM encoding and the display colour palette.
package wave_pkg;

    localparam int DW_DEF    = 10;
    localparam int AW_DEF    = 10;
    localparam int DEPTH_DEF = 800;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARM       = 3'd1,
        ST_WAIT_TRIG = 3'd2,
        ST_CAPTURE   = 3'd3,
        ST_DONE      = 3'd4
    } cap_state_e;

    // RGB565 colours shared with the pixel generator
    localparam logic [15:0] COL_BG    = 16'h0000;
    localparam logic [15:0] COL_GRID  = 16'h4208;
    localparam logic [15:0] COL_TRACE = 16'hFFE0;

endpackage

// File: rtl/wave_capture_ctrl_if.sv
// Sample/control/display-read bundle between the ADC front end, the
// capture controller (slave) and its driver (master).
interface wave_capture_ctrl_if
    import wave_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
);
    logic          run;
    logic          single;
    logic          adc_valid;
    logic [DW-1:0] adc_data;
    logic [DW-1:0] trig_level;
    logic [3:0]    decim;
    logic          frame_start;
    logic [AW-1:0] pixel_xpos;
    logic [DW-1:0] wave_data;
    logic [AW-1:0] wave_addr;
    logic          capturing;
    logic          trace_ready;

    modport master (
        output run, single, adc_valid, adc_data, trig_level, decim,
               frame_start, pixel_xpos,
        input  wave_data, wave_addr, capturing, trace_ready
    );

    modport slave (
        input  run, single, adc_valid, adc_data, trig_level, decim,
               frame_start, pixel_xpos,
        output wave_data, wave_addr, capturing, trace_ready
    );
endinterface

// File: rtl/wave_pingpong_buf.sv
// Two DEPTH x DW trace banks in one RAM: one write port, one registered
// read port, each with its own bank select.
module wave_pingpong_buf #(
    parameter int DW    = 10,
    parameter int DEPTH = 800,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic          wr_bank,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          rd_bank,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    localparam int          IW       = AW + 1;
    localparam logic [IW-1:0] BANK_OFS = IW'(DEPTH);

    logic [DW-1:0] mem_r [2*DEPTH];
    logic [DW-1:0] rdata_q;
    logic [IW-1:0] widx_s;
    logic [IW-1:0] ridx_s;

    // Bank 1 occupies the upper DEPTH entries
    always_comb begin
        widx_s = wr_bank ? (BANK_OFS + {1'b0, waddr}) : {1'b0, waddr};
        ridx_s = rd_bank ? (BANK_OFS + {1'b0, raddr}) : {1'b0, raddr};
    end

    // Write port; contents are deliberately not reset so this maps to block RAM
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[widx_s] <= wdata;
        end
    end

    // Registered read port
    always_ff @(posedge clk) begin
        rdata_q <= mem_r[ridx_s];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/wave_capture_ctrl.sv
// Trigger/capture sequencer: decimation, rising-edge level trigger,
// ping-pong trace storage swapped at frame start.
// Optional AUTO_TRIG_EN adds a free-running auto-trigger after TIMEOUT strobes.
module wave_capture_ctrl
    import wave_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF
`ifdef AUTO_TRIG_EN
    , parameter int TIMEOUT = 65535
`endif
) (
    input  logic                 lcd_clk,
    input  logic                 sys_rst_n,
    wave_capture_ctrl_if.slave   bus
);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [AW:0]   DEPTH_W   = (AW + 1)'(DEPTH);

    cap_state_e    state_q, state_d;
    logic [3:0]    dcnt_q, dcnt_d;
    logic [DW-1:0] prev_q, prev_d;
    logic          prev_valid_q, prev_valid_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic          disp_bank_q, disp_bank_d;
    logic          bank_valid_q, bank_valid_d;
    logic          stopped_q, stopped_d;
    logic          capturing_q, capturing_d;
    logic          trace_ready_q, trace_ready_d;
    logic          rd_ok_q, rd_ok_d;
    logic [AW-1:0] wave_addr_q, wave_addr_d;

    logic          ds_s, hit_s, trig_s, we_s, in_range_s;
    logic [AW-1:0] waddr_s, raddr_s;
    logic [DW-1:0] rdata_s;

`ifdef AUTO_TRIG_EN
    logic [15:0]   tcnt_q, tcnt_d;
    assign trig_s = hit_s || (tcnt_q == 16'(TIMEOUT));
`else
    assign trig_s = hit_s;
`endif

    assign ds_s       = bus.adc_valid && (dcnt_q == bus.decim);
    assign hit_s      = prev_valid_q && (prev_q < bus.trig_level) &&
                        (bus.adc_data >= bus.trig_level);
    assign in_range_s = ({1'b0, bus.pixel_xpos} < DEPTH_W);
    assign raddr_s    = in_range_s ? bus.pixel_xpos : '0;

    // Next-state, capture write and bank-swap decisions
    always_comb begin
        state_d       = state_q;
        prev_d        = prev_q;
        prev_valid_d  = prev_valid_q;
        wr_ptr_d      = wr_ptr_q;
        disp_bank_d   = disp_bank_q;
        bank_valid_d  = bank_valid_q;
        stopped_d     = bus.run ? stopped_q : 1'b0;
        trace_ready_d = 1'b0;
        we_s          = 1'b0;
        waddr_s       = wr_ptr_q;
`ifdef AUTO_TRIG_EN
        tcnt_d        = tcnt_q;
`endif
        if (state_q == ST_ARM) begin
            dcnt_d = 4'd0;
        end else if (bus.adc_valid) begin
            dcnt_d = (dcnt_q >= bus.decim) ? 4'd0 : (dcnt_q + 4'd1);
        end else begin
            dcnt_d = dcnt_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.run && !stopped_q) begin
                    state_d = ST_ARM;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ARM: begin
                prev_valid_d = 1'b0;
                state_d      = bus.run ? ST_WAIT_TRIG : ST_IDLE;
            end
            ST_WAIT_TRIG: begin
                if (!bus.run) begin
                    state_d = ST_IDLE;
                end else if (ds_s) begin
                    prev_d       = bus.adc_data;
                    prev_valid_d = 1'b1;
                    if (trig_s) begin
                        we_s     = 1'b1;
                        waddr_s  = '0;
                        wr_ptr_d = AW'(1);
                        state_d  = ST_CAPTURE;
                    end else begin
`ifdef AUTO_TRIG_EN
                        tcnt_d  = tcnt_q + 16'd1;
`endif
                        state_d = ST_WAIT_TRIG;
                    end
                end else begin
                    state_d = ST_WAIT_TRIG;
                end
            end
            ST_CAPTURE: begin
                if (!bus.run) begin
                    state_d = ST_IDLE;
                end else if (ds_s) begin
                    we_s = 1'b1;
                    if (wr_ptr_q == LAST_ADDR) begin
                        wr_ptr_d = '0;
                        state_d  = ST_DONE;
                    end else begin
                        wr_ptr_d = wr_ptr_q + AW'(1);
                    end
                end else begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_DONE: begin
                // A completed trace is swapped even if run has dropped
                if (bus.frame_start) begin
                    disp_bank_d   = ~disp_bank_q;
                    bank_valid_d  = 1'b1;
                    trace_ready_d = 1'b1;
                    if (bus.single) begin
                        stopped_d = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        state_d = bus.run ? ST_ARM : ST_IDLE;
                    end
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

`ifdef AUTO_TRIG_EN
        if (state_d != ST_WAIT_TRIG) begin
            tcnt_d = 16'd0;
        end else begin
            tcnt_d = tcnt_d;
        end
`endif
        capturing_d = (state_d == ST_CAPTURE);
        rd_ok_d     = bank_valid_q && in_range_s;
        wave_addr_d = bus.pixel_xpos;
    end

    // Control state and registered outputs
    always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q       <= ST_IDLE;
            dcnt_q        <= 4'd0;
            prev_q        <= '0;
            prev_valid_q  <= 1'b0;
            wr_ptr_q      <= '0;
            disp_bank_q   <= 1'b0;
            bank_valid_q  <= 1'b0;
            stopped_q     <= 1'b0;
            capturing_q   <= 1'b0;
            trace_ready_q <= 1'b0;
            rd_ok_q       <= 1'b0;
            wave_addr_q   <= '0;
`ifdef AUTO_TRIG_EN
            tcnt_q        <= 16'd0;
`endif
        end else begin
            state_q       <= state_d;
            dcnt_q        <= dcnt_d;
            prev_q        <= prev_d;
            prev_valid_q  <= prev_valid_d;
            wr_ptr_q      <= wr_ptr_d;
            disp_bank_q   <= disp_bank_d;
            bank_valid_q  <= bank_valid_d;
            stopped_q     <= stopped_d;
            capturing_q   <= capturing_d;
            trace_ready_q <= trace_ready_d;
            rd_ok_q       <= rd_ok_d;
            wave_addr_q   <= wave_addr_d;
`ifdef AUTO_TRIG_EN
            tcnt_q        <= tcnt_d;
`endif
        end
    end

    wave_pingpong_buf #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_buf (
        .clk     (lcd_clk),
        .we      (we_s),
        .wr_bank (~disp_bank_q),
        .waddr   (waddr_s),
        .wdata   (bus.adc_data),
        .rd_bank (disp_bank_q),
        .raddr   (raddr_s),
        .rdata   (rdata_s)
    );

    assign bus.wave_data   = rd_ok_q ? rdata_s : '0;
    assign bus.wave_addr   = wave_addr_q;
    assign bus.capturing   = capturing_q;
    assign bus.trace_ready = trace_ready_q;

endmodule

// File: tb/tb_wave_capture_ctrl.sv
// Directed bench for wave_capture_ctrl: ramp/constant ADC stimulus with
// hand-computed trigger points, swap timing and display read-back values.
module tb_wave_capture_ctrl;
    logic lcd_clk   = 1'b0;
    logic sys_rst_n = 1'b0;
    int   n_pass    = 0;
    int   n_chk     = 0;
    int   ramp      = 0;
    int   fixed_val = -1;

    always #5 lcd_clk = ~lcd_clk;

    wave_capture_ctrl_if #(.DW(10), .AW(10)) bus ();

`ifdef AUTO_TRIG_EN
    wave_capture_ctrl #(.DW(10), .DEPTH(800), .AW(10), .TIMEOUT(16)) dut (
        .lcd_clk(lcd_clk), .sys_rst_n(sys_rst_n), .bus(bus));
`else
    wave_capture_ctrl #(.DW(10), .DEPTH(800), .AW(10)) dut (
        .lcd_clk(lcd_clk), .sys_rst_n(sys_rst_n), .bus(bus));
`endif

    // One clock of ADC stimulus; outputs are sampled 1 ns after the edge
    task automatic cyc(input logic fs);
        bus.adc_data    = (fixed_val >= 0) ? 10'(fixed_val) : 10'(ramp);
        bus.adc_valid   = 1'b1;
        bus.frame_start = fs;
        @(posedge lcd_clk);
        #1;
        ramp++;
        bus.frame_start = 1'b0;
    endtask

    task automatic do_reset(input logic [3:0] dec, input logic sgl);
        sys_rst_n      = 1'b0;
        bus.run        = 1'b1;
        bus.single     = sgl;
        bus.decim      = dec;
        bus.adc_valid  = 1'b0;
        bus.adc_data   = 10'd0;
        bus.trig_level = 10'd512;
        bus.frame_start = 1'b0;
        bus.pixel_xpos = 10'd0;
        ramp           = 0;
        fixed_val      = -1;
        repeat (3) @(posedge lcd_clk);
        #1;
        sys_rst_n = 1'b1;
    endtask

    // Runs until capturing rises; returns the triggering sample value
    task automatic wait_cap(input int bound, output int tval);
        tval = -1;
        for (int i = 0; i < bound && tval < 0; i++) begin
            cyc(1'b0);
            if (bus.capturing === 1'b1) tval = (ramp - 1) % 1024;
        end
        n_chk++;
        if (tval < 0) $display("FAIL wait_cap: no trigger within %0d cycles, expected one", bound);
        else n_pass++;
    endtask

    task automatic wait_done(input int bound);
        int k;
        k = 0;
        while (bus.capturing === 1'b1 && k < bound) begin
            cyc(1'b0);
            k++;
        end
        n_chk++;
        if (bus.capturing !== 1'b0) $display("FAIL wait_done: capturing=%b after %0d cycles, expected 0", bus.capturing, bound);
        else n_pass++;
    endtask

    task automatic test_reset();
        sys_rst_n      = 1'b0;
        bus.run        = 1'b1;
        bus.single     = 1'b0;
        bus.decim      = 4'd0;
        bus.adc_valid  = 1'b1;
        bus.adc_data   = 10'd600;
        bus.trig_level = 10'd512;
        bus.frame_start = 1'b1;
        bus.pixel_xpos = 10'd5;
        repeat (2) @(posedge lcd_clk);
        #1;
        n_chk++; if (bus.capturing !== 1'b0) $display("FAIL rst_capturing: got %b expected 0", bus.capturing); else n_pass++;
        n_chk++; if (bus.trace_ready !== 1'b0) $display("FAIL rst_trace_ready: got %b expected 0", bus.trace_ready); else n_pass++;
        n_chk++; if (bus.wave_data !== 10'd0) $display("FAIL rst_wave_data: got %0d expected 0", bus.wave_data); else n_pass++;
        n_chk++; if (bus.wave_addr !== 10'd0) $display("FAIL rst_wave_addr: got %0d expected 0", bus.wave_addr); else n_pass++;
        bus.frame_start = 1'b0;
        do_reset(4'd0, 1'b0);
        bus.pixel_xpos = 10'd5;
        cyc(1'b0);
        cyc(1'b0);
        n_chk++; if (bus.wave_addr !== 10'd5) $display("FAIL pre_swap_addr: got %0d expected 5", bus.wave_addr); else n_pass++;
        n_chk++; if (bus.wave_data !== 10'd0) $display("FAIL pre_swap_data: got %0d expected 0", bus.wave_data); else n_pass++;
    endtask

    task automatic test_basic();
        int t;
        int xs [5] = '{5, 0, 799, 800, 1023};
        int ex [5] = '{517, 512, 287, 0, 0};
        do_reset(4'd0, 1'b0);
        wait_cap(1100, t);
        n_chk++; if (t != 512) $display("FAIL basic_trig_sample: got %0d expected 512", t); else n_pass++;
        repeat (798) cyc(1'b0);
        n_chk++; if (bus.capturing !== 1'b1) $display("FAIL basic_cap_798: got %b expected 1", bus.capturing); else n_pass++;
        cyc(1'b0);
        n_chk++; if (bus.capturing !== 1'b0) $display("FAIL basic_cap_799: got %b expected 0", bus.capturing); else n_pass++;
        repeat (10) cyc(1'b0);
        n_chk++; if (bus.trace_ready !== 1'b0) $display("FAIL basic_no_early_ready: got %b expected 0", bus.trace_ready); else n_pass++;
        cyc(1'b1);
        n_chk++; if (bus.trace_ready !== 1'b1) $display("FAIL basic_ready_pulse: got %b expected 1", bus.trace_ready); else n_pass++;
        cyc(1'b0);
        n_chk++; if (bus.trace_ready !== 1'b0) $display("FAIL basic_ready_width: got %b expected 0", bus.trace_ready); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            bus.pixel_xpos = 10'(xs[i]);
            cyc(1'b0);
            n_chk++; if (bus.wave_data !== 10'(ex[i])) $display("FAIL basic_read_x%0d: got %0d expected %0d", xs[i], bus.wave_data, ex[i]); else n_pass++;
            n_chk++; if (bus.wave_addr !== 10'(xs[i])) $display("FAIL basic_addr_x%0d: got %0d expected %0d", xs[i], bus.wave_addr, xs[i]); else n_pass++;
        end
    endtask

    task automatic test_done_on_frame();
        int t;
        int nr;
        do_reset(4'd0, 1'b0);
        wait_cap(1100, t);
        repeat (798) cyc(1'b0);
        cyc(1'b1);
        n_chk++; if (bus.capturing !== 1'b0) $display("FAIL dof_capturing: got %b expected 0", bus.capturing); else n_pass++;
        n_chk++; if (bus.trace_ready !== 1'b0) $display("FAIL dof_same_cycle_ready: got %b expected 0", bus.trace_ready); else n_pass++;
        nr = 0;
        repeat (30) begin
            cyc(1'b0);
            if (bus.trace_ready === 1'b1) nr++;
        end
        n_chk++; if (nr != 0) $display("FAIL dof_no_swap: got %0d pulses expected 0", nr); else n_pass++;
        cyc(1'b1);
        n_chk++; if (bus.trace_ready !== 1'b1) $display("FAIL dof_next_frame_ready: got %b expected 1", bus.trace_ready); else n_pass++;
    endtask

    task automatic test_decim();
        int t;
        int cols [6] = '{0, 1, 2, 3, 798, 799};
        int e;
        do_reset(4'd3, 1'b0);
        bus.trig_level = 10'd100;
        wait_cap(1000, t);
        n_chk++; if (t != 101) $display("FAIL decim_trig_sample: got %0d expected 101", t); else n_pass++;
        wait_done(4000);
        cyc(1'b1);
        n_chk++; if (bus.trace_ready !== 1'b1) $display("FAIL decim_ready: got %b expected 1", bus.trace_ready); else n_pass++;
        for (int i = 0; i < 6; i++) begin
            bus.pixel_xpos = 10'(cols[i]);
            cyc(1'b0);
            e = (101 + 4 * cols[i]) % 1024;
            n_chk++; if (bus.wave_data !== 10'(e)) $display("FAIL decim_col%0d: got %0d expected %0d", cols[i], bus.wave_data, e); else n_pass++;
        end
    endtask

    // Relies on the decimated trace left displayed by test_decim
    task automatic test_run_drop();
        int t;
        int nr;
        int cols [3] = '{0, 1, 799};
        int ex   [3] = '{101, 105, 225};
        bus.run = 1'b0;
        repeat (3) cyc(1'b0);
        bus.decim      = 4'd0;
        bus.trig_level = 10'd512;
        bus.run        = 1'b1;
        wait_cap(2100, t);
        n_chk++; if (t != 512) $display("FAIL drop_trig_sample: got %0d expected 512", t); else n_pass++;
        repeat (299) cyc(1'b0);
        bus.run = 1'b0;
        cyc(1'b0);
        n_chk++; if (bus.capturing !== 1'b0) $display("FAIL drop_capturing: got %b expected 0", bus.capturing); else n_pass++;
        nr = 0;
        repeat (4) begin
            cyc(1'b1);
            if (bus.trace_ready === 1'b1) nr++;
            cyc(1'b0);
            if (bus.trace_ready === 1'b1) nr++;
        end
        n_chk++; if (nr != 0) $display("FAIL drop_no_swap: got %0d pulses expected 0", nr); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            bus.pixel_xpos = 10'(cols[i]);
            cyc(1'b0);
            n_chk++; if (bus.wave_data !== 10'(ex[i])) $display("FAIL drop_keep_col%0d: got %0d expected %0d", cols[i], bus.wave_data, ex[i]); else n_pass++;
        end
    endtask

    task automatic test_single();
        int t;
        int nr;
        int nc;
        do_reset(4'd0, 1'b1);
        wait_cap(1100, t);
        wait_done(900);
        cyc(1'b1);
        n_chk++; if (bus.trace_ready !== 1'b1) $display("FAIL single_ready: got %b expected 1", bus.trace_ready); else n_pass++;
        nr = 0;
        nc = 0;
        for (int i = 1; i <= 1500; i++) begin
            cyc((i % 100) == 0);
            if (bus.trace_ready === 1'b1) nr++;
            if (bus.capturing === 1'b1) nc++;
        end
        n_chk++; if (nr != 0) $display("FAIL single_extra_ready: got %0d pulses expected 0", nr); else n_pass++;
        n_chk++; if (nc != 0) $display("FAIL single_rearmed: got %0d capture cycles expected 0", nc); else n_pass++;
        bus.pixel_xpos = 10'd5;
        cyc(1'b0);
        n_chk++; if (bus.wave_data !== 10'd517) $display("FAIL single_col5: got %0d expected 517", bus.wave_data); else n_pass++;
    endtask

    task automatic test_const();
        do_reset(4'd0, 1'b0);
        fixed_val = 200;
`ifdef AUTO_TRIG_EN
        // 2 set-up cycles (IDLE, ARM) then 17 strobes: capture seen after 19 edges
        for (int i = 1; i <= 19; i++) begin
            cyc(1'b0);
            if (i == 18) begin
                n_chk++; if (bus.capturing !== 1'b0) $display("FAIL auto_early: got %b expected 0", bus.capturing); else n_pass++;
            end else if (i == 19) begin
                n_chk++; if (bus.capturing !== 1'b1) $display("FAIL auto_fire: got %b expected 1", bus.capturing); else n_pass++;
            end
        end
        wait_done(900);
        cyc(1'b1);
        bus.pixel_xpos = 10'd10;
        cyc(1'b0);
        n_chk++; if (bus.wave_data !== 10'd200) $display("FAIL auto_col10: got %0d expected 200", bus.wave_data); else n_pass++;
`else
        begin
            int nc;
            nc = 0;
            repeat (300) begin
                cyc(1'b0);
                if (bus.capturing === 1'b1) nc++;
            end
            n_chk++; if (nc != 0) $display("FAIL normal_no_trig: got %0d capture cycles expected 0", nc); else n_pass++;
        end
`endif
        fixed_val = -1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_done_on_frame();
        test_decim();
        test_run_drop();
        test_single();
        test_const();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/wave_capture_ctrl.md
Name: wave_capture_ctrl

Overview:
Trigger/capture sequencer for the waveform display path. Decimates incoming ADC samples and detects a rising-edge level trigger. Writes DEPTH post-trigger samples into a ping-pong buffer. Swaps banks only at frame start, so the pixel generator always reads one stable, complete trace, indexed by pixel_xpos, through wave_data.

Parameters:
DW, 10, sample width (matches pixel generator data/coordinate width)
DEPTH, 800, samples per trace (one per screen column)
AW, 10, buffer address width; DEPTH <= 2**AW
TIMEOUT, 65535, auto-trigger timeout in decimated samples (AUTO_TRIG_EN only)

Ports:
lcd_clk  in  1  display/system clock
sys_rst_n  in  1  asynchronous active-low reset
run  in  1  1 = acquisition enabled
single  in  1  1 = stop (IDLE) after one completed swap
adc_valid  in  1  sample strobe
adc_data  in  DW  sample value
trig_level  in  DW  trigger threshold
decim  in  4  keep 1 of every decim+1 valid samples
frame_start  in  1  one-cycle pulse at pixel (0,0)
pixel_xpos  in  AW  display read column
wave_data  out  DW  stored sample for pixel_xpos
wave_addr  out  AW  column that wave_data belongs to
capturing  out  1  high in CAPTURE
trace_ready  out  1  pulse on the bank-swap cycle

Behaviour:
- Reset: all outputs 0; state IDLE; display bank 0; decim counter 0; prev_valid 0. Buffer contents are not reset; both banks read as 0 until the first swap, gated by a bank_valid flag.
- Decimated strobe: ds = adc_valid && dcnt==decim. dcnt increments on adc_valid and wraps to 0 after decim. dcnt is cleared on entry to ARM.
- States and transitions:
  - IDLE: go to ARM when run=1.
  - ARM: clear prev_valid and dcnt. Next cycle go to WAIT_TRIG.
  - WAIT_TRIG: on ds, the trigger fires when prev_valid && prev < trig_level && adc_data >= trig_level (unsigned). Then prev <= adc_data and prev_valid <= 1. On trigger: write the triggering sample at address 0, set wr_ptr=1, go to CAPTURE.
  - CAPTURE: on ds, write adc_data to the capture bank at wr_ptr and increment wr_ptr. When the write at DEPTH-1 completes, go to DONE.
  - DONE: on frame_start, swap banks, pulse trace_ready, set bank_valid. Then go to IDLE if single=1, else to ARM.
- DONE entered on the same cycle as frame_start: the swap waits for the next frame_start.
- run=0 in ARM/WAIT_TRIG/CAPTURE: return to IDLE next cycle and discard the partial capture (no swap). run=0 in DONE: the pending swap still completes, then go to IDLE.
- Reset mid-capture: immediate return to the reset state; display bank 0, bank_valid 0.
- Read path:
  - wave_data and wave_addr are registered; latency 1 cycle from pixel_xpos.
  - pixel_xpos >= DEPTH, or bank_valid=0: wave_data=0. wave_addr=pixel_xpos always.
  - Reads always target the display bank; writes always target the other bank. No read/write collision is possible.
- Widths: comparisons are unsigned DW-bit. wr_ptr is AW bits and never exceeds DEPTH-1.

Optional Feature:
AUTO_TRIG_EN
- Defined: WAIT_TRIG counts ds strobes in a 16-bit counter. At TIMEOUT with no trigger, force a trigger on the next ds and capture as normal. The counter clears on leaving WAIT_TRIG. The free-running display is roll-free.
- Undefined: no counter; WAIT_TRIG waits indefinitely (normal-mode scope).

Decomposition:
- Shared package wave_pkg:
  - DW/AW/DEPTH defaults.
  - State encoding: IDLE=0, ARM=1, WAIT_TRIG=2, CAPTURE=3, DONE=4 (3-bit).
  - Colour constants already used by the display side.
- Sub-module wave_pingpong_buf: two DEPTH x DW banks, one write port, one registered read port, bank select input. It is inferable as block RAM.
- FSM, decimator and trigger logic stay in wave_capture_ctrl.

Test Plan:
- Reset with run=1, then a ramp 0..1023 on every cycle, decim=0, trig_level=512, pulse frame_start → capture starts at sample 512, trace_ready pulses at the first frame_start after 800 writes, and pixel_xpos=5 gives wave_data=517 one cycle later.
- decim=3, same ramp, trig_level=100 → the stored column n equals the sample at decimated index n past the trigger; consecutive stored values differ by 4.
- DONE reached on the frame_start cycle → no swap that frame; trace_ready fires at the following frame_start only.
- run dropped mid-CAPTURE at wr_ptr=300 → return to IDLE; no trace_ready; the displayed trace is unchanged.
- single=1 → exactly one trace_ready, then IDLE; a later frame_start causes no swap.
- Constant input 200 with trig_level=512:
  - With AUTO_TRIG_EN and TIMEOUT=16 → capture starts after 17 ds strobes.
  - Without AUTO_TRIG_EN → the block stays in WAIT_TRIG.
- pixel_xpos=800..1023 → wave_data=0.
